// File: rtl/usb2_ulpi_link.sv
// rtl/usb2_ulpi_link.sv - ULPI link layer: turnaround, RX CMD/data split, TX handshake, optional PHY init (ULPI_INIT_EN)
module usb2_ulpi_link #(
    parameter logic [15:0] PWRUP_DELAY   = 16'd1024,
    parameter logic [7:0]  FUNC_CTRL_VAL = 8'h40
) (
    input  logic       phy_clk,
    input  logic       reset_n,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    input  logic [7:0] ulpi_data_in,
    output logic [7:0] ulpi_data_out,
    output logic       ulpi_data_oe,
    output logic       ulpi_stp,
    output logic       in_act,
    output logic [7:0] in_byte,
    output logic       in_latch,
    output logic       out_cts,
    output logic       out_nxt,
    input  logic [7:0] out_byte,
    input  logic       out_latch,
    input  logic       out_stp,
    output logic [1:0] line_state,
    output logic [1:0] vbus_state,
    output logic       err_rx,
    output logic       err_tx_abort
);

`ifdef ULPI_INIT_EN
    // RegWrite TX CMD to Function Control (address 0x04)
    localparam logic [7:0] REGW_FUNC_CTRL = 8'h84;

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_INIT_CMD  = 3'd1,
        ST_INIT_DATA = 3'd2,
        ST_INIT_STP  = 3'd3,
        ST_IDLE      = 3'd4,
        ST_TX        = 3'd5,
        ST_TX_STP    = 3'd6,
        ST_RX        = 3'd7
    } state_t;

    logic init_done;
`else
    typedef enum logic [2:0] {
        ST_PWRUP  = 3'd0,
        ST_IDLE   = 3'd4,
        ST_TX     = 3'd5,
        ST_TX_STP = 3'd6,
        ST_RX     = 3'd7
    } state_t;

    // The Function Control value is only consumed by the init sequence
    logic unused_func_ctrl;
    assign unused_func_ctrl = ^FUNC_CTRL_VAL;
`endif

    state_t      state;
    logic        dir_q;
    logic        link_en;
    logic [15:0] pwrup_cnt;
    logic        pwrup_last;

    // Counting from 0, the last power-up cycle is PWRUP_DELAY-1; 17-bit compare keeps PWRUP_DELAY=0 sane
    assign pwrup_last = ({1'b0, pwrup_cnt} + 17'd1) >= {1'b0, PWRUP_DELAY};

    // One dead cycle on every dir edge; nothing is driven until power-up has finished
    assign ulpi_data_oe = link_en & ~dir_q & ~ulpi_dir;
    assign out_cts      = (state == ST_IDLE) & ~dir_q & ~ulpi_dir;
    assign out_nxt      = (state == ST_TX) & ulpi_nxt & ~ulpi_dir;

    // Receive side: RX CMD bytes update status, data bytes are forwarded with one register stage
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q      <= 1'b0;
            in_act     <= 1'b0;
            in_byte    <= 8'h00;
            in_latch   <= 1'b0;
            line_state <= 2'b00;
            vbus_state <= 2'b00;
            err_rx     <= 1'b0;
        end else begin
            dir_q    <= ulpi_dir;
            in_latch <= 1'b0;
            if (ulpi_dir && dir_q) begin
                if (ulpi_nxt) begin
                    if (in_act) begin
                        in_byte  <= ulpi_data_in;
                        in_latch <= 1'b1;
                    end
                end else begin
                    line_state <= ulpi_data_in[1:0];
                    vbus_state <= ulpi_data_in[3:2];
                    in_act     <= ulpi_data_in[4];
                    if (ulpi_data_in[5:4] == 2'b11) begin
                        err_rx <= 1'b1;
                    end
                end
            end else if (ulpi_dir && !dir_q) begin
                // nxt on the rise turnaround means the PHY is starting a packet right away
                if (ulpi_nxt) begin
                    in_act <= 1'b1;
                end
            end else if (!ulpi_dir && dir_q) begin
                in_act <= 1'b0;
            end
        end
    end

    // Link FSM: power-up wait, optional register setup, transmit handshake and bus ownership
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_PWRUP;
            pwrup_cnt     <= 16'd0;
            link_en       <= 1'b0;
            ulpi_data_out <= 8'h00;
            ulpi_stp      <= 1'b0;
            err_tx_abort  <= 1'b0;
`ifdef ULPI_INIT_EN
            init_done     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_PWRUP: begin
                    if (pwrup_cnt != 16'hFFFF) begin
                        pwrup_cnt <= pwrup_cnt + 16'd1;
                    end
                    if (pwrup_last) begin
                        link_en <= 1'b1;
`ifdef ULPI_INIT_EN
                        ulpi_data_out <= REGW_FUNC_CTRL;
                        state         <= ST_INIT_CMD;
`else
                        ulpi_data_out <= 8'h00;
                        state         <= ST_IDLE;
`endif
                    end
                end
`ifdef ULPI_INIT_EN
                ST_INIT_CMD: begin
                    if (ulpi_dir) begin
                        ulpi_data_out <= 8'h00;
                        state         <= ST_RX;
                    end else if (ulpi_nxt && !dir_q) begin
                        ulpi_data_out <= FUNC_CTRL_VAL;
                        state         <= ST_INIT_DATA;
                    end
                end
                ST_INIT_DATA: begin
                    if (ulpi_dir) begin
                        ulpi_data_out <= 8'h00;
                        state         <= ST_RX;
                    end else if (ulpi_nxt && !dir_q) begin
                        ulpi_data_out <= 8'h00;
                        ulpi_stp      <= 1'b1;
                        state         <= ST_INIT_STP;
                    end
                end
                ST_INIT_STP: begin
                    ulpi_stp  <= 1'b0;
                    init_done <= 1'b1;
                    state     <= ulpi_dir ? ST_RX : ST_IDLE;
                end
`endif
                ST_IDLE: begin
                    ulpi_stp <= 1'b0;
                    if (ulpi_dir) begin
                        // A TX request on the same cycle is dropped; the packet layer retries on out_cts
                        ulpi_data_out <= 8'h00;
                        state         <= ST_RX;
                    end else if (out_latch && !dir_q) begin
                        ulpi_data_out <= out_byte;
                        state         <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (ulpi_dir) begin
                        // PHY took the bus mid-packet: release it without stp and let RX run
                        err_tx_abort  <= 1'b1;
                        ulpi_data_out <= 8'h00;
                        state         <= ST_RX;
                    end else if (out_stp) begin
                        ulpi_stp      <= 1'b1;
                        ulpi_data_out <= 8'h00;
                        state         <= ST_TX_STP;
                    end else if (out_nxt && out_latch) begin
                        ulpi_data_out <= out_byte;
                    end
                end
                ST_TX_STP: begin
                    ulpi_stp <= 1'b0;
                    state    <= ulpi_dir ? ST_RX : ST_IDLE;
                end
                ST_RX: begin
                    ulpi_data_out <= 8'h00;
                    ulpi_stp      <= 1'b0;
                    if (!ulpi_dir) begin
`ifdef ULPI_INIT_EN
                        // An interrupted register write restarts from its command byte
                        if (init_done) begin
                            state <= ST_IDLE;
                        end else begin
                            ulpi_data_out <= REGW_FUNC_CTRL;
                            state         <= ST_INIT_CMD;
                        end
`else
                        state <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    state <= ST_PWRUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb2_ulpi_link.sv
// tb/tb_usb2_ulpi_link.sv - randomized self-checking bench for usb2_ulpi_link
module tb_usb2_ulpi_link;
    localparam logic [15:0] PWRUP = 16'd8;
    localparam logic [7:0]  FCTRL = 8'h40;

    logic       phy_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ulpi_dir = 1'b0;
    logic       ulpi_nxt = 1'b0;
    logic [7:0] ulpi_data_in = 8'h00;
    logic [7:0] ulpi_data_out;
    logic       ulpi_data_oe;
    logic       ulpi_stp;
    logic       in_act;
    logic [7:0] in_byte;
    logic       in_latch;
    logic       out_cts;
    logic       out_nxt;
    logic [7:0] out_byte = 8'h00;
    logic       out_latch = 1'b0;
    logic       out_stp = 1'b0;
    logic [1:0] line_state;
    logic [1:0] vbus_state;
    logic       err_rx;
    logic       err_tx_abort;

    int   checks = 0;
    int   errors = 0;
    logic exp_err_rx = 1'b0;
    logic exp_tx_abort = 1'b0;

    usb2_ulpi_link #(.PWRUP_DELAY(PWRUP), .FUNC_CTRL_VAL(FCTRL)) dut (
        .phy_clk(phy_clk), .reset_n(reset_n),
        .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_data_in(ulpi_data_in),
        .ulpi_data_out(ulpi_data_out), .ulpi_data_oe(ulpi_data_oe), .ulpi_stp(ulpi_stp),
        .in_act(in_act), .in_byte(in_byte), .in_latch(in_latch),
        .out_cts(out_cts), .out_nxt(out_nxt),
        .out_byte(out_byte), .out_latch(out_latch), .out_stp(out_stp),
        .line_state(line_state), .vbus_state(vbus_state),
        .err_rx(err_rx), .err_tx_abort(err_tx_abort)
    );

    always #5 phy_clk = ~phy_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge phy_clk);
        #1;
    endtask

    task automatic idle_inputs;
        ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_in = 8'h00;
        out_latch = 1'b0; out_stp = 1'b0; out_byte = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, ulpi_data_out, 0);
        check({tag, "_oe"}, ulpi_data_oe, 0);
        check({tag, "_stp"}, ulpi_stp, 0);
        check({tag, "_in_act"}, in_act, 0);
        check({tag, "_in_byte"}, in_byte, 0);
        check({tag, "_in_latch"}, in_latch, 0);
        check({tag, "_cts"}, out_cts, 0);
        check({tag, "_out_nxt"}, out_nxt, 0);
        check({tag, "_line"}, line_state, 0);
        check({tag, "_vbus"}, vbus_state, 0);
        check({tag, "_err_rx"}, err_rx, 0);
        check({tag, "_err_abort"}, err_tx_abort, 0);
    endtask

    // Called right after reset_n is released; the bus must stay unused for PWRUP cycles
    task automatic powerup;
        int unsigned stalls;
        for (int i = 1; i < int'(PWRUP); i++) begin
            tick;
            check("pwrup_cts", out_cts, 0);
            check("pwrup_oe", ulpi_data_oe, 0);
        end
        tick;
`ifdef ULPI_INIT_EN
        stalls = $urandom_range(0, 3);
        for (int s = 0; s < int'(stalls); s++) begin
            check("init_cmd_hold", ulpi_data_out, 8'h84);
            check("init_cmd_oe", ulpi_data_oe, 1);
            check("init_cmd_cts", out_cts, 0);
            tick;
        end
        check("init_cmd", ulpi_data_out, 8'h84);
        ulpi_nxt = 1'b1;
        tick;
        ulpi_nxt = 1'b0;
        stalls = $urandom_range(0, 3);
        for (int s = 0; s < int'(stalls); s++) begin
            check("init_data_hold", ulpi_data_out, FCTRL);
            tick;
        end
        check("init_data", ulpi_data_out, FCTRL);
        check("init_data_cts", out_cts, 0);
        ulpi_nxt = 1'b1;
        tick;
        ulpi_nxt = 1'b0;
        check("init_stp", ulpi_stp, 1);
        check("init_stp_data", ulpi_data_out, 0);
        #1 check("init_stp_cts", out_cts, 0);
        tick;
        check("init_stp_end", ulpi_stp, 0);
`else
        stalls = 0;
        check("pwrup_stp", ulpi_stp + stalls, 0);
`endif
        #1 check("pwrup_done_cts", out_cts, 1);
        check("pwrup_done_oe", ulpi_data_oe, 1);
    endtask

    task automatic wait_cts;
        for (int i = 0; i < 50 && !out_cts; i++) tick;
        check("cts_timeout", out_cts, 1);
    endtask

    task automatic rx_turn(input logic nxt);
        ulpi_dir = 1'b1; ulpi_nxt = nxt; ulpi_data_in = 8'($urandom);
        #1 check("rx_turn_oe", ulpi_data_oe, 0);
        check("rx_turn_cts", out_cts, 0);
        tick;
        check("rx_turn_act", in_act, nxt);
        check("rx_turn_latch", in_latch, 0);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        ulpi_nxt = 1'b1; ulpi_data_in = b;
        tick;
        check("rx_latch", in_latch, 1);
        check("rx_byte", in_byte, b);
        check("rx_act", in_act, 1);
    endtask

    task automatic rx_cmd(input logic [7:0] c);
        ulpi_nxt = 1'b0; ulpi_data_in = c;
        tick;
        if (c[5:4] == 2'b11) exp_err_rx = 1'b1;
        check("rxcmd_line", line_state, c[1:0]);
        check("rxcmd_vbus", vbus_state, c[3:2]);
        check("rxcmd_act", in_act, c[4]);
        check("rxcmd_latch", in_latch, 0);
        check("rxcmd_err_rx", err_rx, exp_err_rx);
    endtask

    task automatic rx_bytes(input int len);
        logic [7:0] c;
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                c = {4'b0001, 4'($urandom)};
                rx_cmd(c);
            end
            rx_byte(8'($urandom));
        end
    endtask

    task automatic rx_end;
        ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_in = 8'h00;
        #1 check("rx_fall_oe", ulpi_data_oe, 0);
        tick;
        check("rx_fall_act", in_act, 0);
        check("rx_fall_latch", in_latch, 0);
        #1 check("rx_fall_cts", out_cts, 1);
        check("rx_fall_data", ulpi_data_out, 0);
    endtask

    task automatic tx_packet(input logic [7:0] first, input int len, input int abort_at, input int fixed_stall);
        logic [7:0] pkt [$];
        int unsigned stalls;
        pkt.push_back(first);
        for (int i = 1; i < len; i++) pkt.push_back(8'($urandom));
        wait_cts();
        check("tx_abort_flag", err_tx_abort, exp_tx_abort);
        out_latch = 1'b1; out_byte = pkt[0];
        tick;
        out_latch = 1'b0; out_byte = 8'h00;
        check("tx_first", ulpi_data_out, pkt[0]);
        for (int i = 0; i < len; i++) begin
            stalls = (fixed_stall >= 0) ? fixed_stall : $urandom_range(0, 3);
            for (int s = 0; s < int'(stalls); s++) begin
                #1 check("tx_hold", ulpi_data_out, pkt[i]);
                check("tx_hold_nxt", out_nxt, 0);
                check("tx_oe", ulpi_data_oe, 1);
                check("tx_cts", out_cts, 0);
                tick;
            end
            if (i == abort_at) begin
                ulpi_dir = 1'b1; ulpi_nxt = 1'b1;
                #1 check("abort_oe", ulpi_data_oe, 0);
                check("abort_out_nxt", out_nxt, 0);
                tick;
                exp_tx_abort = 1'b1;
                check("abort_flag", err_tx_abort, 1);
                check("abort_no_stp", ulpi_stp, 0);
                check("abort_in_act", in_act, 1);
                #1 check("abort_cts", out_cts, 0);
                rx_bytes($urandom_range(1, 3));
                rx_end();
                return;
            end
            ulpi_nxt = 1'b1;
            if (i < len - 1) begin
                out_latch = 1'b1; out_byte = pkt[i + 1];
            end
            #1 check("tx_out_nxt", out_nxt, 1);
            check("tx_byte", ulpi_data_out, pkt[i]);
            tick;
            ulpi_nxt = 1'b0; out_latch = 1'b0; out_byte = 8'h00;
        end
        out_stp = 1'b1;
        tick;
        out_stp = 1'b0;
        check("tx_stp", ulpi_stp, 1);
        check("tx_stp_data", ulpi_data_out, 0);
        #1 check("tx_stp_cts", out_cts, 0);
        tick;
        check("tx_stp_end", ulpi_stp, 0);
        #1 check("tx_done_cts", out_cts, 1);
        check("tx_done_data", ulpi_data_out, 0);
    endtask

    initial begin
        logic [7:0] t1 [3];
        int len;
        t1[0] = 8'hC3; t1[1] = 8'h01; t1[2] = 8'h02;

        idle_inputs();
        reset_n = 1'b0;
        repeat (3) tick;
        check_all_zero("reset");
        reset_n = 1'b1;
        powerup();

        // Directed: RX packet C3,01,02 opened with nxt on the turnaround
        rx_turn(1'b1);
        for (int i = 0; i < 3; i++) rx_byte(t1[i]);
        rx_end();

        // Directed: RX CMDs 1D then 0D
        rx_turn(1'b0);
        rx_cmd(8'h1D);
        rx_cmd(8'h0D);
        rx_end();

        // Directed: single-byte TX 4D with three stall cycles
        tx_packet(8'h4D, 1, -1, 3);

        // Directed: out_stp without a preceding out_latch does nothing
        out_stp = 1'b1;
        tick;
        out_stp = 1'b0;
        check("lone_stp", ulpi_stp, 0);
        #1 check("lone_stp_cts", out_cts, 1);

        // Directed: dir and out_latch together in idle, RX wins
        ulpi_dir = 1'b1; ulpi_nxt = 1'b0; out_latch = 1'b1; out_byte = 8'h4A;
        #1 check("race_oe", ulpi_data_oe, 0);
        check("race_cts", out_cts, 0);
        tick;
        out_latch = 1'b0; out_byte = 8'h00;
        check("race_data", ulpi_data_out, 0);
        rx_cmd({4'b0000, 4'($urandom)});
        rx_end();
        tick;
        check("race_no_tx", ulpi_data_out, 0);

        // Randomized mix of RX packets, RX CMD bursts, TX packets and aborted TX
        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(1, 6);
            case ($urandom_range(0, 3))
                0: begin
                    rx_turn(1'b1);
                    rx_bytes(len);
                    rx_end();
                end
                1: begin
                    rx_turn(1'b0);
                    for (int k = 0; k < len; k++) rx_cmd(8'($urandom));
                    rx_end();
                end
                2: tx_packet({4'h4, 4'($urandom)}, len, -1, -1);
                default: tx_packet({4'h4, 4'($urandom)}, len, $urandom_range(0, len - 1), -1);
            endcase
        end

        // Reset pulsed in the middle of an RX packet
        rx_turn(1'b1);
        rx_byte(8'($urandom));
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_rst");
        idle_inputs();
        exp_err_rx = 1'b0;
        exp_tx_abort = 1'b0;
        tick;
        reset_n = 1'b1;
        powerup();
        tx_packet({4'h4, 4'($urandom)}, 3, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
